// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and the iteration-counter width helper.
package div_pkg;

  localparam int unsigned DIV_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Wide enough to hold the value n itself, so the counter never wraps early.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// Combinational (N+1)-bit trial subtractor {R, Qmsb} - {0, D}, built as a
// ripple adder with the subtrahend inverted and carry-in tied to 1.
module div_sub_step #(
  parameter int unsigned N = 8
) (
  input  logic [N:0]   minuend_i,
  input  logic [N-1:0] subtrahend_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N:0] sub_inv;

  assign sub_inv = ~{1'b0, subtrahend_i};

  // When no borrow occurs the difference is below D, so its top bit is
  // always zero and only the low N bits are ever needed.
  always_comb begin : ripple
    logic carry;
    logic sum;
    // NOTE: every variable in a combinational block gets a value before any
    // conditional use, otherwise synthesis infers a latch to hold it.
    carry  = 1'b1;
    sum    = 1'b0;
    diff_o = '0;
    for (int i = 0; i <= N; i++) begin
      sum   = minuend_i[i] ^ sub_inv[i] ^ carry;
      carry = (minuend_i[i] & sub_inv[i]) | (carry & (minuend_i[i] ^ sub_inv[i]));
      if (i < N) diff_o[i] = sum;
    end
    borrow_o = ~carry;
  end

endmodule

// File: rtl/div8_seq.sv
// Sequential restoring divider: one trial subtraction per clock, Start/Done
// handshake, registered quotient/remainder/divide-by-zero results.
module div8_seq
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         div_by_zero_o
);

  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  div_state_e    state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N-1:0]  diff;
  logic          borrow;

  div_sub_step #(.N(N)) u_step (
    .minuend_i    ({r_q, q_q[N-1]}),
    .subtrahend_i (d_q),
    .diff_o       (diff),
    .borrow_o     (borrow)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (divisor_i == '0) begin
            quot_d  = '1;
            rem_d   = dividend_i;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            q_d     = dividend_i;
            r_d     = '0;
            d_d     = divisor_i;
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (borrow) begin
          r_d = {r_q[N-2:0], q_q[N-1]};
          q_d = {q_q[N-2:0], 1'b0};
        end else begin
          r_d = diff;
          q_d = {q_q[N-2:0], 1'b1};
        end
        cnt_d = cnt_q + CW'(1);
        // Results are published straight from the final iteration's next state.
        if (cnt_q == LAST_ITER) begin
          quot_d  = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy_o        = (state_q == ST_RUN);
  assign done_o        = (state_q == ST_DONE);
  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: directed vector table, Start-hold and
// mid-run reset sequences, then random operands against plain arithmetic.
module tb_div8_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dvd;
  logic [N-1:0] dvs;
  logic         busy_o;
  logic         done_o;
  logic [N-1:0] quotient_o;
  logic [N-1:0] remainder_o;
  logic         div_by_zero_o;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] prev_q   = '0;
  logic [N-1:0] prev_r   = '0;
  logic         prev_dbz = 1'b0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } vec_t;

  div8_seq #(.N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .dividend_i    (dvd),
    .divisor_i     (dvs),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one request from a negedge, watches the handshake and returns the
  // results; with hold set, Start stays high and operands switch to 50/5.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold,
                        input string tag, output logic [N-1:0] q, output logic [N-1:0] r,
                        output logic z);
    int  busy_n;
    int  done_idx;
    bit  held_ok;
    dvd   = a;
    dvs   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (hold) begin
      dvd = 8'd50;
      dvs = 8'd5;
    end else begin
      start = 1'b0;
    end
    busy_n   = 0;
    done_idx = -1;
    held_ok  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_o) begin
        done_idx = k;
        break;
      end
      if (busy_o) busy_n++;
      if (quotient_o !== prev_q || remainder_o !== prev_r || div_by_zero_o !== prev_dbz)
        held_ok = 1'b0;
    end
    check({tag, " latency"}, done_idx, (b == 0) ? 0 : N);
    check({tag, " busy_cycles"}, busy_n, (b == 0) ? 0 : N);
    check({tag, " results_held_during_run"}, held_ok, 1);
    q = quotient_o;
    r = remainder_o;
    z = div_by_zero_o;
    @(negedge clk);
    check({tag, " done_single_pulse"}, {busy_o, done_o}, 0);
    prev_q   = q;
    prev_r   = r;
    prev_dbz = z;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[$];
    logic [N-1:0] q, r;
    logic         z;
    logic [N-1:0] a, b;
    bit           saw_done;

    vecs.push_back('{8'd200, 8'd7,   8'd28,  8'd4,   1'b0});
    vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0,   1'b0});
    vecs.push_back('{8'd5,   8'd9,   8'd0,   8'd5,   1'b0});
    vecs.push_back('{8'd0,   8'd3,   8'd0,   8'd0,   1'b0});
    vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,   1'b0});
    vecs.push_back('{8'd100, 8'd0,   8'd255, 8'd100, 1'b1});
    vecs.push_back('{8'd9,   8'd3,   8'd3,   8'd0,   1'b0});

    rst   = 1'b1;
    start = 1'b0;
    dvd   = '0;
    dvs   = '0;
    #12;
    check("reset busy_done", {busy_o, done_o}, 0);
    check("reset quotient", quotient_o, 0);
    check("reset remainder_dbz", {remainder_o, div_by_zero_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, $sformatf("vec%0d", i), q, r, z);
      check($sformatf("vec%0d quotient", i), q, vecs[i].q);
      check($sformatf("vec%0d remainder", i), r, vecs[i].r);
      check($sformatf("vec%0d div_by_zero", i), z, vecs[i].z);
    end

    // Start held through RUN with changing operands, then re-accepted after Done.
    run_op(8'd200, 8'd7, 1'b1, "hold", q, r, z);
    check("hold quotient", q, 28);
    check("hold remainder", r, 4);
    run_op(8'd50, 8'd5, 1'b0, "retry", q, r, z);
    check("retry quotient", q, 10);
    check("retry remainder", r, 0);
    check("retry div_by_zero", z, 0);

    // Leave nonzero results in place so the reset clear is observable.
    run_op(8'd100, 8'd0, 1'b0, "prereset", q, r, z);
    check("prereset results", {q, r, z}, {8'd255, 8'd100, 1'b1});

    dvd   = 8'd200;
    dvs   = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_reset busy_done", {busy_o, done_o}, 0);
    check("midrun_reset results", {quotient_o, remainder_o, div_by_zero_o}, 0);
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done_o || busy_o) saw_done = 1'b1;
    end
    check("midrun_reset no_done", saw_done, 0);
    rst      = 1'b0;
    prev_q   = '0;
    prev_r   = '0;
    prev_dbz = 1'b0;
    @(negedge clk);
    run_op(8'd12, 8'd4, 1'b0, "after_reset", q, r, z);
    check("after_reset results", {q, r, z}, {8'd3, 8'd0, 1'b0});

    for (int n = 0; n < 1000; n++) begin
      a = N'($urandom_range(0, 255));
      b = N'($urandom_range(1, 255));
      run_op(a, b, 1'b0, $sformatf("rand%0d", n), q, r, z);
      check($sformatf("rand%0d quotient", n), q, a / b);
      check($sformatf("rand%0d remainder", n), r, a % b);
      check($sformatf("rand%0d invariant", n), 32'(q) * 32'(b) + 32'(r), 32'(a));
      check($sformatf("rand%0d rem_lt_div", n), (r < b), 1);
      check($sformatf("rand%0d div_by_zero", n), z, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
